count_pulse_gen: RTL and testbench
==================================

// Module: count_pulse_gen
// PURPOSE
//  Upstream front end for the up/down counter stage. Turns a raw push-button
//  input and a raw mode switch into two clean signals:
//   - a single-cycle count pulse (tick), with auto-repeat while the button is held
//   - a debounced direction level (dir: 0 = up, 1 = down, same sense as m)
//  Both inputs are asynchronous. Both outputs are synchronous to clock.
// PARAMETERS
//  DB_CYCLES    4   debounce window, in clocks; input must be stable this long
//  HOLD_CYCLES  16  clocks from the first tick to the first auto-repeat tick
//  REP_CYCLES   4   clocks between consecutive auto-repeat ticks
//  CNT_W        8   timer width; 2**CNT_W > max(DB_CYCLES,HOLD_CYCLES,REP_CYCLES)
// PORTS
//  clock  in   1  system clock; everything is on the rising edge
//  clear  in   1  synchronous reset, active-high
//  btn    in   1  raw push-button, asynchronous, may bounce
//  m      in   1  raw mode switch, asynchronous, may bounce
//  tick   out  1  one-clock count pulse
//  dir    out  1  debounced direction, held stable while a press is in progress
//  busy   out  1  high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset
//   - clear=1 at a rising edge resets all state: tick=0, dir=0, busy=0,
//     FSM=IDLE, timers=0, every synchronizer flop=0.
//   - clear overrides every other condition, including mid-press and mid-repeat.
//  Synchronizers
//   - btn and m each pass through a 2-flop synchronizer, producing btn_s and m_s.
//  Button FSM and timer
//   - Timer resets to 0 on every state change; otherwise it increments each clock.
//   - IDLE: btn_s=1 -> DEB_PRESS.
//   - DEB_PRESS: btn_s=0 -> IDLE (bounce rejected, no tick).
//       Timer==DB_CYCLES-1 with btn_s=1 -> HELD, and tick=1.
//   - HELD: btn_s=0 -> DEB_REL.
//       Timer==HOLD_CYCLES-1 -> REPEAT, and tick=1.
//   - REPEAT: btn_s=0 -> DEB_REL.
//       Timer==REP_CYCLES-1 -> tick=1 and timer=0; stay in REPEAT.
//   - DEB_REL: btn_s=1 -> HELD, timer=0, no tick (release glitch; hold timing restarts).
//       Timer==DB_CYCLES-1 with btn_s=0 -> IDLE.
//  Tick timing
//   - tick is registered and is never high for two consecutive clocks.
//   - Latency: counting the first edge that samples btn=1 as edge 1, tick is
//     high in the cycle after edge DB_CYCLES+3.
//  Direction
//   - m_s is debounced with its own timer: it must differ from dir for DB_CYCLES
//     consecutive clocks.
//   - dir updates only while the FSM is in IDLE. A change that becomes stable
//     during a press is applied after the FSM returns to IDLE and the debounce
//     window completes there.
//   - Consequence: dir is constant from the first tick of a burst to its last.
//  Boundaries
//   - Button held indefinitely: ticks continue every REP_CYCLES; the timer never
//     overflows, because the REPEAT timer wraps at REP_CYCLES-1.
//   - clear deasserted while btn is held: a new debounce starts, and the first
//     tick follows edge DB_CYCLES+3 counted from the first edge after clear.
//  Range check
//   - An out-of-range parameter (any of the three cycle counts <1, or one that
//     does not fit in CNT_W) is a $error at elaboration.
// TESTING (DB_CYCLES=4, HOLD_CYCLES=16, REP_CYCLES=4; edge 1 = first edge sampling btn=1)
//  1. clear=1 for 2 clocks, btn=0, m=1 -> tick=0, dir=0, busy=0 throughout.
//  2. Clean press, btn=1 for 12 clocks then 0 -> exactly one tick, after edge 7;
//     busy returns to 0 within 2+4+1 clocks of release.
//  3. Bounce: btn 1,0,1,0 at one clock each, then stable 1 -> no tick from the
//     glitches; one tick, 7 edges after the final rise.
//  4. Hold btn=1 for 40 clocks -> ticks after edges 7, 23, 27, 31, 35, 39
//     (+ up to 2 more while the release propagates), then none.
//  5. m 0->1 at edge 10 of a 40-clock hold -> dir=0 for every tick in the burst;
//     dir=1 four clocks after IDLE is re-entered.
//  6. clear pulse at edge 30 of a hold, btn kept at 1 -> tick=0 and busy=0 the
//     next cycle; the next tick comes after edge 7 counted from clear release.

Source files
------------

// File: rtl/count_pulse_gen.sv
// count_pulse_gen_sync
//   Two-flop synchronizer for a vector of independent asynchronous bits.
//   Ports:
//     clock  in        system clock
//     clear  in        synchronous reset, active-high (flops go to 0)
//     d      in  [W]   asynchronous inputs
//     q      out [W]   synchronized outputs, two clocks of latency
module count_pulse_gen_sync #(
    parameter int W = 1
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clock) begin
        if (clear) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// count_pulse_gen
//   Push-button front end for the up/down counter. Produces a single-cycle
//   count pulse with auto-repeat while the button is held, and a debounced
//   direction level that only moves while no press is in progress.
//   Ports:
//     clock  in   system clock, rising edge
//     clear  in   synchronous reset, active-high
//     btn    in   raw push-button (asynchronous, bouncy)
//     m      in   raw mode switch (asynchronous, bouncy); 1 = down
//     tick   out  one-clock count pulse
//     dir    out  debounced direction (0 = up, 1 = down)
//     busy   out  high whenever the button FSM is not in IDLE
module count_pulse_gen #(
    parameter int DB_CYCLES   = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int REP_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic clock,
    input  logic clear,
    input  logic btn,
    input  logic m,
    output logic tick,
    output logic dir,
    output logic busy
);
    // Every terminal count must be reachable by a CNT_W-bit timer.
    if (CNT_W < 1 || CNT_W > 30 ||
        DB_CYCLES   < 1 || DB_CYCLES   >= (1 << CNT_W) ||
        HOLD_CYCLES < 1 || HOLD_CYCLES >= (1 << CNT_W) ||
        REP_CYCLES  < 1 || REP_CYCLES  >= (1 << CNT_W)) begin : g_param_err
        $error("count_pulse_gen: cycle-count parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        HELD,
        REPEAT,
        DEB_REL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, timer_nxt;
    logic [CNT_W-1:0] dcnt;
    logic             tick_nxt;
    logic [1:0]       sync_q;
    logic             btn_s, m_s;

    count_pulse_gen_sync #(.W(2)) u_sync (
        .clock (clock),
        .clear (clear),
        .d     ({m, btn}),
        .q     (sync_q)
    );

    assign btn_s = sync_q[0];
    assign m_s   = sync_q[1];
    assign busy  = (state != IDLE);

    always_ff @(posedge clock) begin
        if (clear) begin
            state <= IDLE;
            timer <= '0;
            tick  <= 1'b0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
            tick  <= tick_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer + 1'b1;
        tick_nxt  = 1'b0;
        case (state)
            // Timer parked at 0 in IDLE so it cannot run away between presses.
            IDLE: begin
                timer_nxt = '0;
                if (btn_s) state_nxt = DEB_PRESS;
            end
            DEB_PRESS: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                end else if (timer == DB_LAST) begin
                    state_nxt = HELD;
                    tick_nxt  = 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nxt = DEB_REL;
                end else if (timer == HOLD_LAST) begin
                    state_nxt = REPEAT;
                    tick_nxt  = 1'b1;
                end
            end
            // Wraps at REP_LAST, so an indefinite hold never overflows.
            REPEAT: begin
                if (!btn_s) begin
                    state_nxt = DEB_REL;
                end else if (timer == REP_LAST) begin
                    tick_nxt  = 1'b1;
                    timer_nxt = '0;
                end
            end
            // A brief drop during release goes back to HELD and restarts hold timing.
            DEB_REL: begin
                if (btn_s) begin
                    state_nxt = HELD;
                end else if (timer == DB_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) timer_nxt = '0;
        // With 1-cycle windows two ticks could land back to back; keep them apart.
        if (tick) tick_nxt = 1'b0;
    end

    // Direction debounce. The window only advances in IDLE, so a switch flip
    // during a press waits for the press to end and then debounces in full.
    always_ff @(posedge clock) begin
        if (clear) begin
            dir  <= 1'b0;
            dcnt <= '0;
        end else if (m_s == dir || state != IDLE) begin
            dcnt <= '0;
        end else if (dcnt == DB_LAST) begin
            dir  <= m_s;
            dcnt <= '0;
        end else begin
            dcnt <= dcnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_count_pulse_gen.sv
// Bench for count_pulse_gen (default parameters). Expected ticks (cycle and
// dir) are queued by the stimulus; a negedge monitor pops and compares them.
module tb_count_pulse_gen;
    logic clock = 1'b0;
    logic clear, btn, m;
    logic tick, dir, busy;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int   cyc;
        logic dir;
    } exp_t;
    exp_t sb[$];

    count_pulse_gen #(
        .DB_CYCLES   (4),
        .HOLD_CYCLES (16),
        .REP_CYCLES  (4),
        .CNT_W       (8)
    ) dut (
        .clock (clock),
        .clear (clear),
        .btn   (btn),
        .m     (m),
        .tick  (tick),
        .dir   (dir),
        .busy  (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic adv_to(input int c);
        while (cyc < c) adv(1);
    endtask

    task automatic push(input int c, input logic d);
        exp_t e;
        e.cyc = c;
        e.dir = d;
        sb.push_back(e);
    endtask

    // Monitor: every tick must match the head of the scoreboard.
    logic prev_tick = 1'b0;
    always @(negedge clock) begin
        if (tick === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL tick_unexpected: tick at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.cyc != cyc || e.dir !== dir || prev_tick) begin
                    fails++;
                    $display("FAIL tick: got cycle %0d dir %b prev_tick %b, expected cycle %0d dir %b prev_tick 0",
                             cyc, dir, prev_tick, e.cyc, e.dir);
                end
            end
        end
        prev_tick = (tick === 1'b1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rep_offs[6] = '{7, 23, 27, 31, 35, 39};

        clear = 1'b1;
        btn   = 1'b0;
        m     = 1'b1;

        // 1: reset held two clocks
        adv(1);
        check("rst1_tick", tick, 1'b0);
        check("rst1_dir",  dir,  1'b0);
        check("rst1_busy", busy, 1'b0);
        adv(1);
        check("rst2_tick", tick, 1'b0);
        check("rst2_dir",  dir,  1'b0);
        check("rst2_busy", busy, 1'b0);
        clear = 1'b0;
        m     = 1'b0;
        adv(2);

        // 2: clean 12-clock press
        base = cyc;
        btn  = 1'b1;
        push(base + 7, 1'b0);
        adv_to(base + 12);
        btn = 1'b0;
        adv_to(base + 18);
        check("rel_busy_hi", busy, 1'b1);
        adv(1);
        check("rel_busy_lo", busy, 1'b0);
        adv(3);

        // 3: bounce 1,0,1,0 then stable 1
        base = cyc;
        push(base + 11, 1'b0);
        btn = 1'b1; adv(1);
        btn = 1'b0; adv(1);
        btn = 1'b1; adv(1);
        btn = 1'b0; adv(1);
        btn = 1'b1;
        adv_to(base + 14);
        btn = 1'b0;
        adv_to(base + 25);
        check("bounce_busy", busy, 1'b0);

        // 4: 40-clock hold, auto-repeat
        base = cyc;
        btn  = 1'b1;
        foreach (rep_offs[i]) push(base + rep_offs[i], 1'b0);
        adv_to(base + 40);
        btn = 1'b0;
        adv_to(base + 50);
        check("hold_busy", busy, 1'b0);

        // 5: mode flips mid-burst; dir only follows after IDLE + window
        base = cyc;
        btn  = 1'b1;
        foreach (rep_offs[i]) push(base + rep_offs[i], 1'b0);
        adv_to(base + 9);
        m = 1'b1;
        adv_to(base + 40);
        btn = 1'b0;
        adv_to(base + 46);
        check("m_busy_hi", busy, 1'b1);
        adv(1);
        check("m_busy_lo", busy, 1'b0);
        adv_to(base + 50);
        check("m_dir_old", dir, 1'b0);
        adv(1);
        check("m_dir_new", dir, 1'b1);

        // 6: clear pulse at edge 30 of a hold with btn kept high
        base = cyc;
        btn  = 1'b1;
        push(base + 7,  1'b1);
        push(base + 23, 1'b1);
        push(base + 27, 1'b1);
        adv_to(base + 29);
        clear = 1'b1;
        adv(1);
        clear = 1'b0;
        check("clr_tick", tick, 1'b0);
        check("clr_busy", busy, 1'b0);
        check("clr_dir",  dir,  1'b0);
        push(base + 37, 1'b0);
        adv_to(base + 40);
        btn = 1'b0;
        adv_to(base + 55);
        check("clr_dir_after", dir,  1'b1);
        check("clr_busy_end",  busy, 1'b0);

        adv(2);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d expected ticks never seen, required 0 (next cycle %0d)",
                     sb.size(), sb[0].cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
